// File: rtl/alu_seq.sv
// Registered ALU with a valid/ready operand handshake and an iterative
// shift-add multiplier. Single-cycle ops complete in one cycle; MUL takes WIDTH.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             out_valid
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_SLTU = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_XOR  = 3'b111;

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_mcand;
  logic [WIDTH-1:0]  r_mier;
  logic [WIDTH-1:0]  r_acc;
  logic [CW-1:0]     r_cnt;
  logic [WIDTH-1:0]  r_out;
  logic              r_cout;
  logic              r_ovf;
  logic              r_zero;
  logic              r_out_valid;

  logic [WIDTH:0]    w_add;
  logic [WIDTH:0]    w_sub;
  logic [WIDTH-1:0]  w_res;
  logic              w_cout;
  logic              w_ovf;
  logic [WIDTH-1:0]  w_acc_step;
  logic              w_accept;
  logic              w_mul_done;

  assign in_ready   = (r_state == IDLE);
  assign w_accept   = in_valid & in_ready;
  assign w_mul_done = (r_state == BUSY) && (r_cnt == CNT_LAST);
  assign w_add      = {1'b0, A} + {1'b0, B};
  // carry of A + ~B + 1 is set exactly when no borrow occurs (A >= B)
  assign w_sub      = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
  assign w_acc_step = r_mier[0] ? (r_acc + r_mcand) : r_acc;

  always_comb begin
    w_res  = '0;
    w_cout = 1'b0;
    w_ovf  = 1'b0;
    case (op)
      OP_AND:  w_res = A & B;
      OP_OR:   w_res = A | B;
      OP_XOR:  w_res = A ^ B;
      OP_ADD: begin
        w_res  = w_add[WIDTH-1:0];
        w_cout = w_add[WIDTH];
        w_ovf  = (A[WIDTH-1] == B[WIDTH-1]) & (w_add[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        w_res  = w_sub[WIDTH-1:0];
        w_cout = w_sub[WIDTH];
        w_ovf  = (A[WIDTH-1] != B[WIDTH-1]) & (w_sub[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (A < B)};
      default: w_res = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept && op == OP_MUL) w_state_nxt = BUSY;
      BUSY:    if (w_mul_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand     <= '0;
      r_mier      <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (r_state == BUSY) begin
        r_acc   <= w_acc_step;
        r_mcand <= r_mcand << 1;
        r_mier  <= r_mier >> 1;
        r_cnt   <= r_cnt + CW'(1);
        if (w_mul_done) begin
          r_out       <= w_acc_step;
          r_cout      <= 1'b0;
          r_ovf       <= 1'b0;
          r_zero      <= (w_acc_step == '0);
          r_out_valid <= 1'b1;
        end
      end else if (w_accept) begin
        if (op == OP_MUL) begin
          r_mcand <= A;
          r_mier  <= B;
          r_acc   <= '0;
          r_cnt   <= '0;
        end else begin
          r_out       <= w_res;
          r_cout      <= w_cout;
          r_ovf       <= w_ovf;
          r_zero      <= (w_res == '0);
          r_out_valid <= 1'b1;
        end
      end
    end
  end

  assign out       = r_out;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=32 and WIDTH=8 instances).
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A, B;
  logic [2:0]  op;
  logic [31:0] out;
  logic        cout, ovf, zero, out_valid;

  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  A8, B8;
  logic [2:0]  op8;
  logic [7:0]  out8;
  logic        cout8, ovf8, zero8, out_valid8;

  int total = 0;
  int bad   = 0;
  int n;
  int pulses;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .op(op), .out(out), .cout(cout), .ovf(ovf),
    .zero(zero), .out_valid(out_valid)
  );

  alu_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .A(A8), .B(B8), .op(op8), .out(out8), .cout(cout8), .ovf(ovf8),
    .zero(zero8), .out_valid(out_valid8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    op = o;
    A = a;
    B = b;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; op = 3'b000;
    in_valid8 = 1'b0; A8 = '0; B8 = '0; op8 = 3'b000;
    step();
    step();
    rst = 1'b0;
    check("rst_out", 64'(out), 64'h0);
    check("rst_zero", 64'(zero), 64'h1);
    check("rst_valid", 64'(out_valid), 64'h0);
    check("rst_ready", 64'(in_ready), 64'h1);

    // ADD with carry and overflow
    issue(3'b010, 32'h8000_0000, 32'h8000_0000);
    step();
    in_valid = 1'b0;
    check("add_valid", 64'(out_valid), 64'h1);
    check("add_out", 64'(out), 64'h0);
    check("add_flags", 64'({cout, ovf, zero}), 64'h7);
    step();
    check("idle_valid", 64'(out_valid), 64'h0);
    check("idle_hold", 64'({out, cout, ovf, zero}), 64'h7);

    issue(3'b010, 32'h7FFF_FFFF, 32'h0000_0001);
    step();
    check("add2_out", 64'(out), 64'h8000_0000);
    check("add2_flags", 64'({cout, ovf, zero}), 64'h2);

    // SLT then SLTU back to back
    issue(3'b100, 32'hFFFF_FFFF, 32'h0000_0001);
    step();
    check("slt_valid", 64'(out_valid), 64'h1);
    check("slt_out", 64'(out), 64'h1);
    issue(3'b101, 32'hFFFF_FFFF, 32'h0000_0001);
    step();
    in_valid = 1'b0;
    check("sltu_valid", 64'(out_valid), 64'h1);
    check("sltu_out", 64'(out), 64'h0);
    check("sltu_zero", 64'(zero), 64'h1);
    step();
    check("sltu_pulse_end", 64'(out_valid), 64'h0);

    // SUB cases
    issue(3'b011, 32'h0000_0003, 32'h0000_0005);
    step();
    check("sub1_out", 64'(out), 64'hFFFF_FFFE);
    check("sub1_flags", 64'({cout, ovf, zero}), 64'h0);
    issue(3'b011, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    step();
    check("sub2_out", 64'(out), 64'h8000_0000);
    check("sub2_flags", 64'({cout, ovf, zero}), 64'h2);
    issue(3'b011, 32'h0000_0005, 32'h0000_0003);
    step();
    check("sub3_out", 64'(out), 64'h2);
    check("sub3_flags", 64'({cout, ovf, zero}), 64'h4);

    // Logic ops
    issue(3'b111, 32'hF0F0_F0F0, 32'hFF00_FF00);
    step();
    check("xor_out", 64'(out), 64'h0FF0_0FF0);
    issue(3'b001, 32'h1234_0000, 32'h0000_5678);
    step();
    check("or_out", 64'(out), 64'h1234_5678);
    check("or_flags", 64'({cout, ovf, zero}), 64'h0);

    // MUL followed by an AND accepted on the result cycle
    issue(3'b110, 32'h0001_0003, 32'h0000_0005);
    step();
    in_valid = 1'b0;
    n = 0; pulses = 0;
    while (!in_ready && n < 40) begin
      if (out_valid) pulses++;
      step();
      n++;
    end
    check("mul1_busy_cycles", 64'(n), 64'd32);
    check("mul1_early_pulse", 64'(pulses), 64'd0);
    check("mul1_valid", 64'(out_valid), 64'h1);
    check("mul1_out", 64'(out), 64'h0005_000F);
    issue(3'b000, 32'h341B_928C, 32'h1234_0149);
    step();
    in_valid = 1'b0;
    check("and_valid", 64'(out_valid), 64'h1);
    check("and_out", 64'(out), 64'h1010_0008);

    issue(3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step();
    in_valid = 1'b0;
    n = 0;
    while (!in_ready && n < 40) begin
      step();
      n++;
    end
    check("mul2_busy_cycles", 64'(n), 64'd32);
    check("mul2_out", 64'(out), 64'h1);
    check("mul2_flags", 64'({cout, ovf, zero, out_valid}), 64'h1);

    // Reset in the middle of a multiply
    issue(3'b110, 32'h0000_1234, 32'h0000_5678);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) step();
    check("mulrst_busy", 64'(in_ready), 64'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mulrst_ready", 64'(in_ready), 64'h1);
    check("mulrst_out", 64'(out), 64'h0);
    check("mulrst_zero", 64'(zero), 64'h1);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) pulses++;
      step();
    end
    check("mulrst_no_pulse", 64'(pulses), 64'd0);

    // WIDTH=8 multiply
    in_valid8 = 1'b1; op8 = 3'b110; A8 = 8'h0F; B8 = 8'h11;
    step();
    in_valid8 = 1'b0;
    n = 0;
    while (!in_ready8 && n < 20) begin
      step();
      n++;
    end
    check("mul8_busy_cycles", 64'(n), 64'd8);
    check("mul8_valid", 64'(out_valid8), 64'h1);
    check("mul8_out", 64'(out8), 64'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 32-bit combinational ALU.
- Adds XOR, signed and unsigned set-less-than, carry/overflow/zero flags, and an iterative shift-add multiplier.
- Operands enter through a valid/ready handshake; results leave as a registered output with a one-cycle valid pulse.
- Sits between the register-file read stage and writeback in the datapath.

Parameters:
WIDTH, 32, operand/result width in bits (>= 4).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operands and op are valid this cycle.
in_ready  output  1  block can accept; equals (state == IDLE), combinational.
A  input  WIDTH  operand A.
B  input  WIDTH  operand B.
op  input  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT (signed), 101 SLTU, 110 MUL (low WIDTH bits), 111 XOR.
out  output  WIDTH  registered result; holds until the next result.
cout  output  1  carry flag (see Behaviour).
ovf  output  1  signed overflow flag (ADD/SUB only).
zero  output  1  1 when out == 0.
out_valid  output  1  one-cycle pulse when out and the flags are updated.

Behaviour:
- Reset: one clk edge with rst=1 forces state=IDLE, out=0, cout=0, ovf=0, zero=1, out_valid=0, and clears the multiplier counter and accumulator.
  - rst has priority over everything, including a multiply in flight; the partial product is discarded and no out_valid is produced.
- Accept: occurs at a rising edge where in_valid & in_ready. A, B and op are sampled only on that edge.
- Single-cycle ops (all except MUL): on the accept edge, out, cout, ovf and zero are written and out_valid=1 for the following cycle. Latency is 1; the state stays IDLE, so back-to-back accepts are possible every cycle.
- MUL:
  - On the accept edge, latch multiplicand=A, multiplier=B, acc=0, cnt=0, and go to BUSY.
  - In BUSY, each edge: if multiplier[0], acc += multiplicand (mod 2^WIDTH); then multiplicand <<= 1, multiplier >>= 1, cnt++.
  - On the edge where cnt reaches WIDTH: out=acc (final add included), flags written, state=IDLE, out_valid=1. Result visible WIDTH cycles after accept.
  - in_ready=0 throughout BUSY; in_valid is ignored there.
  - in_ready returns to 1 in the same cycle out_valid is high, so a new accept is legal in that cycle.
- State machine: IDLE -(accept & op==MUL)-> BUSY; BUSY -(cnt==WIDTH)-> IDLE; any state -(rst)-> IDLE.
- Arithmetic, all mod 2^WIDTH:
  - ADD: out=A+B; cout = carry out of bit WIDTH-1; ovf = (A[msb]==B[msb]) & (out[msb]!=A[msb]).
  - SUB: out=A+~B+1; cout=1 iff A>=B unsigned (no borrow); ovf = (A[msb]!=B[msb]) & (out[msb]!=A[msb]).
  - SLT: out={0..,1} iff $signed(A) < $signed(B). SLTU: out={0..,1} iff A < B unsigned.
  - AND, OR, XOR, SLT, SLTU, MUL: cout=0, ovf=0.
  - zero is computed from the new out for every op.
- out_valid is a pulse with no back-pressure; the consumer must take the result in that cycle. out and the flags are stable until the next update.
- Undefined op values cannot occur, since all 8 encodings are defined.
- in_valid=0 on a cycle leaves out and the flags unchanged and drives out_valid=0.

Test Plan (WIDTH=32 unless stated):
1. ADD A=0x80000000 B=0x80000000, in_valid for one cycle -> next cycle out_valid=1, out=0x00000000, cout=1, ovf=1, zero=1.
2. SLT A=0xFFFFFFFF B=0x00000001 -> out=0x00000001. SLTU with the same operands on the next cycle (back-to-back) -> out=0x00000000, zero=1. out_valid is high for two consecutive cycles.
3. SUB A=0x00000003 B=0x00000005 -> out=0xFFFFFFFE, cout=0, ovf=0. SUB A=0x7FFFFFFF B=0xFFFFFFFF -> out=0x80000000, ovf=1.
4. MUL A=0x00010003 B=0x00000005 -> in_ready=0 for 32 cycles, then out_valid=1 with out=0x0005000F. A new AND (0x341B928C & 0x12340149 = 0x10100008) accepted in that cycle is valid one cycle later.
5. MUL A=0xFFFFFFFF B=0xFFFFFFFF -> out=0x00000001 after 32 cycles. Repeat with WIDTH=8, A=0x0F, B=0x11 -> out=0xFF after 8 cycles.
6. Start MUL, assert rst at busy cycle 10 -> next cycle state IDLE, in_ready=1, out=0, zero=1. No out_valid appears in the following 40 cycles without new input.
